// File: rtl/cpu_ctrl_decode_pkg.sv
// Shared micro-state codes and control-word bit positions for the CPU control path.
// Datapath blocks index the registered ctrl word by these names.
package cpu_ctrl_decode_pkg;

    localparam int CTRL_W = 16;

    localparam logic [7:0] STATE_FETCH_PC   = 8'h00;
    localparam logic [7:0] STATE_FETCH_INST = 8'h01;
    localparam logic [7:0] STATE_FETCH_SP   = 8'h02;
    localparam logic [7:0] STATE_INC_SP     = 8'h03;
    localparam logic [7:0] STATE_SET_REG    = 8'h04;
    localparam logic [7:0] STATE_MOV_FETCH  = 8'h05;
    localparam logic [7:0] STATE_MOV_LOAD   = 8'h06;
    localparam logic [7:0] STATE_MOV_STORE  = 8'h07;
    localparam logic [7:0] STATE_ALU_OP     = 8'h08;
    localparam logic [7:0] STATE_JUMP       = 8'h09;
    localparam logic [7:0] STATE_REG_STORE  = 8'h0A;
    localparam logic [7:0] STATE_PC_STORE   = 8'h0B;
    localparam logic [7:0] STATE_TMP_JUMP   = 8'h0C;
    localparam logic [7:0] STATE_RET        = 8'h0D;
    localparam logic [7:0] STATE_SET_ADDR   = 8'h0E;
    localparam logic [7:0] STATE_OUT        = 8'h0F;
    localparam logic [7:0] STATE_IN         = 8'h10;
    localparam logic [7:0] STATE_NEXT       = 8'h11;
    localparam logic [7:0] STATE_HALT       = 8'h12;

    localparam int CTL_PC_OE    = 0;
    localparam int CTL_PC_INC   = 1;
    localparam int CTL_PC_LOAD  = 2;
    localparam int CTL_IR_LOAD  = 3;
    localparam int CTL_MEM_OE   = 4;
    localparam int CTL_MEM_WE   = 5;
    localparam int CTL_SP_OE    = 6;
    localparam int CTL_SP_INC   = 7;
    localparam int CTL_SP_DEC   = 8;
    localparam int CTL_REG_OE   = 9;
    localparam int CTL_REG_WE   = 10;
    localparam int CTL_ALU_OE   = 11;
    localparam int CTL_TMP_LOAD = 12;
    localparam int CTL_IO_OE    = 13;
    localparam int CTL_IO_WE    = 14;
    localparam int CTL_MAR_LOAD = 15;

    function automatic logic [CTRL_W-1:0] ctl(input int idx);
        return CTRL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/cpu_ctrl_rom.sv
// Combinational micro-state to control-word lookup; valid drops for unknown codes.
module cpu_ctrl_rom
    import cpu_ctrl_decode_pkg::*;
#(
    parameter int STATE_W = 8
) (
    input  logic [STATE_W-1:0] state,
    output logic [15:0]        ctrl_word,
    output logic               valid
);

    always_comb begin
        ctrl_word = '0;
        valid     = 1'b1;
        case (state)
            STATE_FETCH_PC:   ctrl_word = ctl(CTL_PC_OE) | ctl(CTL_MAR_LOAD) | ctl(CTL_PC_INC);
            STATE_FETCH_INST: ctrl_word = ctl(CTL_MEM_OE) | ctl(CTL_IR_LOAD);
            STATE_FETCH_SP:   ctrl_word = ctl(CTL_SP_OE) | ctl(CTL_MAR_LOAD);
            STATE_INC_SP:     ctrl_word = ctl(CTL_SP_INC);
            STATE_SET_REG:    ctrl_word = ctl(CTL_MEM_OE) | ctl(CTL_REG_WE);
            STATE_MOV_FETCH:  ctrl_word = ctl(CTL_REG_OE) | ctl(CTL_TMP_LOAD);
            STATE_MOV_LOAD:   ctrl_word = ctl(CTL_PC_OE) | ctl(CTL_MAR_LOAD) | ctl(CTL_PC_INC);
            STATE_MOV_STORE:  ctrl_word = ctl(CTL_MEM_OE) | ctl(CTL_REG_WE);
            STATE_ALU_OP:     ctrl_word = ctl(CTL_ALU_OE) | ctl(CTL_REG_WE);
            STATE_JUMP:       ctrl_word = ctl(CTL_MEM_OE) | ctl(CTL_PC_LOAD);
            STATE_REG_STORE:  ctrl_word = ctl(CTL_REG_OE) | ctl(CTL_MEM_WE) | ctl(CTL_SP_DEC);
            STATE_PC_STORE:   ctrl_word = ctl(CTL_PC_OE) | ctl(CTL_MEM_WE) | ctl(CTL_SP_DEC);
            STATE_TMP_JUMP:   ctrl_word = ctl(CTL_MEM_OE) | ctl(CTL_PC_LOAD);
            STATE_RET:        ctrl_word = ctl(CTL_MEM_OE) | ctl(CTL_PC_LOAD);
            STATE_SET_ADDR:   ctrl_word = ctl(CTL_MEM_OE) | ctl(CTL_MAR_LOAD);
            STATE_OUT:        ctrl_word = ctl(CTL_REG_OE) | ctl(CTL_IO_WE);
            STATE_IN:         ctrl_word = ctl(CTL_IO_OE) | ctl(CTL_REG_WE);
            STATE_NEXT:       ctrl_word = '0;
            STATE_HALT:       ctrl_word = '0;
            default:          valid     = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_decode.sv
// Registers the decoded control word on the falling edge and owns the IR, halt latch,
// cycle_clr pulse and bad-state pulse.
module cpu_ctrl_decode
    import cpu_ctrl_decode_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int STATE_W = 8
) (
    input  logic               clk,
    input  logic               reset_cycle,
    input  logic [STATE_W-1:0] state,
    input  logic [DATA_W-1:0]  bus_in,
    output logic [DATA_W-1:0]  opcode,
    output logic [2:0]         sel_dst,
    output logic [2:0]         sel_src,
    output logic [15:0]        ctrl,
    output logic               cycle_clr,
    output logic               halted,
    output logic               bad_state
);

    logic [15:0]       rom_word;
    logic              rom_valid;
    logic [15:0]       ctrl_d, ctrl_q;
    logic              clr_d, clr_q;
    logic              halted_d, halted_q;
    logic              bad_d, bad_q;
    logic [DATA_W-1:0] ir_q;

    cpu_ctrl_rom #(.STATE_W(STATE_W)) u_rom (
        .state     (state),
        .ctrl_word (rom_word),
        .valid     (rom_valid)
    );

    // Halt dominates everything; an undecodable code only raises bad_state.
    always_comb begin
        ctrl_d   = '0;
        clr_d    = 1'b0;
        halted_d = halted_q;
        bad_d    = 1'b0;
        if (!halted_q) begin
            if (!rom_valid) begin
                bad_d = 1'b1;
            end else begin
                ctrl_d   = rom_word;
                clr_d    = (state == STATE_W'(STATE_NEXT));
                halted_d = (state == STATE_W'(STATE_HALT));
            end
        end
    end

    always_ff @(negedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            ctrl_q   <= '0;
            clr_q    <= 1'b0;
            halted_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            clr_q    <= clr_d;
            halted_q <= halted_d;
            bad_q    <= bad_d;
        end
    end

    // ctrl is already zero while halted, so ir_load alone freezes the IR.
    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            ir_q <= '0;
        end else if (ctrl_q[CTL_IR_LOAD]) begin
            ir_q <= bus_in;
        end
    end

    assign opcode    = ir_q;
    assign sel_dst   = ir_q[5:3];
    assign sel_src   = ir_q[2:0];
    assign ctrl      = ctrl_q;
    assign cycle_clr = clr_q;
    assign halted    = halted_q;
    assign bad_state = bad_q;

endmodule

// File: tb/tb_cpu_ctrl_decode.sv
// Directed bench for cpu_ctrl_decode: decode table, IR capture, NEXT pulse, halt, bad code, async reset.
module tb_cpu_ctrl_decode;
    import cpu_ctrl_decode_pkg::*;

    logic        clk;
    logic        reset_cycle;
    logic [7:0]  state;
    logic [7:0]  bus_in;
    logic [7:0]  opcode;
    logic [2:0]  sel_dst;
    logic [2:0]  sel_src;
    logic [15:0] ctrl;
    logic        cycle_clr;
    logic        halted;
    logic        bad_state;

    int n_cmp;
    int n_err;

    cpu_ctrl_decode dut (
        .clk         (clk),
        .reset_cycle (reset_cycle),
        .state       (state),
        .bus_in      (bus_in),
        .opcode      (opcode),
        .sel_dst     (sel_dst),
        .sel_src     (sel_src),
        .ctrl        (ctrl),
        .cycle_clr   (cycle_clr),
        .halted      (halted),
        .bad_state   (bad_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a posedge: present a state, then sample just after the negedge.
    task automatic drive_state(input logic [7:0] s);
        state = s;
        @(negedge clk);
        #1;
    endtask

    task automatic to_posedge();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  tbl_state [17];
    logic [15:0] tbl_ctrl  [17];

    initial begin
        n_cmp = 0;
        n_err = 0;
        tbl_state = '{STATE_FETCH_PC, STATE_FETCH_INST, STATE_FETCH_SP, STATE_INC_SP,
                      STATE_SET_REG, STATE_MOV_FETCH, STATE_MOV_LOAD, STATE_MOV_STORE,
                      STATE_ALU_OP, STATE_JUMP, STATE_REG_STORE, STATE_PC_STORE,
                      STATE_TMP_JUMP, STATE_RET, STATE_SET_ADDR, STATE_OUT, STATE_IN};
        tbl_ctrl  = '{16'h8003, 16'h0018, 16'h8040, 16'h0080,
                      16'h0410, 16'h1200, 16'h8003, 16'h0410,
                      16'h0C00, 16'h0014, 16'h0320, 16'h0121,
                      16'h0014, 16'h0014, 16'h8010, 16'h4200, 16'h2400};

        reset_cycle = 1'b1;
        state       = STATE_FETCH_INST;
        bus_in      = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ctrl", ctrl, 16'h0000);
        check_val("rst_opcode", {8'h00, opcode}, 16'h0000);
        check_val("rst_halted", {15'd0, halted}, 16'h0000);
        check_val("rst_clr", {15'd0, cycle_clr}, 16'h0000);
        check_val("rst_bad", {15'd0, bad_state}, 16'h0000);

        reset_cycle = 1'b0;
        drive_state(STATE_FETCH_PC);
        check_val("fetch_pc", ctrl, 16'h8003);
        to_posedge();

        bus_in = 8'h5A;
        drive_state(STATE_FETCH_INST);
        check_val("fetch_inst", ctrl, 16'h0018);
        check_val("ir_before_edge", {8'h00, opcode}, 16'h0000);
        to_posedge();
        check_val("ir_load", {8'h00, opcode}, 16'h005A);
        check_val("sel_dst", {13'd0, sel_dst}, 16'h0003);
        check_val("sel_src", {13'd0, sel_src}, 16'h0002);
        bus_in = 8'hC3;
        drive_state(STATE_INC_SP);
        to_posedge();
        check_val("ir_hold", {8'h00, opcode}, 16'h005A);

        for (int i = 0; i < 17; i++) begin
            if (tbl_state[i] == STATE_FETCH_INST) bus_in = 8'h5A;
            drive_state(tbl_state[i]);
            check_val($sformatf("decode_%02h", tbl_state[i]), ctrl, tbl_ctrl[i]);
            check_val("decode_no_bad", {15'd0, bad_state}, 16'h0000);
            to_posedge();
        end

        // single NEXT pulse
        drive_state(STATE_NEXT);
        check_val("next_clr", {15'd0, cycle_clr}, 16'h0001);
        check_val("next_ctrl", ctrl, 16'h0000);
        to_posedge();
        check_val("next_clr_held", {15'd0, cycle_clr}, 16'h0001);
        drive_state(STATE_FETCH_PC);
        check_val("next_clr_end", {15'd0, cycle_clr}, 16'h0000);
        check_val("after_next", ctrl, 16'h8003);
        to_posedge();

        // back-to-back NEXT
        drive_state(STATE_NEXT);
        to_posedge();
        drive_state(STATE_NEXT);
        check_val("next2_clr", {15'd0, cycle_clr}, 16'h0001);
        to_posedge();
        drive_state(STATE_INC_SP);
        check_val("next2_clr_end", {15'd0, cycle_clr}, 16'h0000);
        check_val("next2_after", ctrl, 16'h0080);
        to_posedge();

        // undefined code
        drive_state(8'hEE);
        check_val("bad_pulse", {15'd0, bad_state}, 16'h0001);
        check_val("bad_ctrl", ctrl, 16'h0000);
        check_val("bad_no_halt", {15'd0, halted}, 16'h0000);
        to_posedge();
        drive_state(STATE_FETCH_SP);
        check_val("bad_clear", {15'd0, bad_state}, 16'h0000);
        check_val("bad_recover", ctrl, 16'h8040);
        to_posedge();

        // async reset during the low phase with ALU_OP control active
        drive_state(STATE_ALU_OP);
        check_val("alu_op", ctrl, 16'h0C00);
        #2;
        reset_cycle = 1'b1;
        #1;
        check_val("async_rst_ctrl", ctrl, 16'h0000);
        check_val("async_rst_ir", {8'h00, opcode}, 16'h0000);
        state = STATE_FETCH_INST;
        to_posedge();
        to_posedge();
        check_val("rst_no_capture", {8'h00, opcode}, 16'h0000);
        reset_cycle = 1'b0;
        drive_state(STATE_IN);
        check_val("post_rst_decode", ctrl, 16'h2400);
        to_posedge();

        // load a known opcode, then halt
        bus_in = 8'h3C;
        drive_state(STATE_FETCH_INST);
        to_posedge();
        check_val("ir_3c", {8'h00, opcode}, 16'h003C);
        drive_state(STATE_HALT);
        check_val("halt_set", {15'd0, halted}, 16'h0001);
        check_val("halt_ctrl", ctrl, 16'h0000);
        to_posedge();
        drive_state(STATE_FETCH_PC);
        check_val("halted_fetch_pc", ctrl, 16'h0000);
        check_val("halted_sticky", {15'd0, halted}, 16'h0001);
        to_posedge();
        drive_state(STATE_NEXT);
        check_val("halted_no_clr", {15'd0, cycle_clr}, 16'h0000);
        to_posedge();
        drive_state(8'hEE);
        check_val("halted_no_bad", {15'd0, bad_state}, 16'h0000);
        to_posedge();
        bus_in = 8'hFF;
        drive_state(STATE_FETCH_INST);
        check_val("halted_inst_ctrl", ctrl, 16'h0000);
        to_posedge();
        check_val("halted_ir_frozen", {8'h00, opcode}, 16'h003C);

        reset_cycle = 1'b1;
        #1;
        check_val("halt_rst", {15'd0, halted}, 16'h0000);
        to_posedge();
        reset_cycle = 1'b0;
        drive_state(STATE_OUT);
        check_val("unhalt_decode", ctrl, 16'h4200);
        to_posedge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
